// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the two-port APB master controller.
package apb_ctrl_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  // Width of the ACCESS wait counter; bounds the legal TIMEOUT range.
  localparam int TIMEOUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_t;

endpackage

// File: rtl/apb_master_arb_if.sv
// APB bus bundle between the master controller and a single slave.
interface apb_master_arb_if
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, pwrite, pwdata, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, pwdata, psel, penable,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_rr_arb2.sv
// Two-input round-robin grant: on a tie the requester that did not win last time wins.
module apb_rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // Pick the winning index, then expand it to a one-hot grant.
  always_comb begin
    gnt_idx = 1'b0;
    case (req_valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = 1'b0;
    endcase
    gnt = (|req_valid) ? {gnt_idx, ~gnt_idx} : 2'b00;
  end

endmodule

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// bounded wait for pready and a one-cycle response pulse to the winner.
//
// Requester handshake: a requester raises req_valid[i] with stable write/addr/wdata
// and holds them until it sees req_ready[i]; the request is consumed in the cycle
// where req_valid[i] & req_ready[i]. req_ready is only offered in IDLE. The answer
// comes back as a one-cycle rsp_valid[i] pulse with rsp_err/rsp_rdata alongside;
// there is no back-pressure on responses.
module apb_master_arb
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  apb_master_arb_if.master    bus,
  output apb_mst_state_t      dbg_state
);

  apb_mst_state_t       state_q, state_d;
  logic                 last_q, last_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

  logic [1:0]           gnt;
  logic                 gnt_idx;
  logic [TIMEOUT_W-1:0] cnt_inc;
  logic                 timeout_hit;

  apb_rr_arb2 u_arb (
    .req_valid (req_valid),
    .last      (last_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  // The TIMEOUT-th low-pready ACCESS cycle ends the transfer.
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = !bus.pready && (cnt_inc == TIMEOUT_W'(TIMEOUT));

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (bus.pready || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: decodes of the current state and registered datapath.
  always_comb begin
    req_ready   = (state_q == IDLE) ? gnt : 2'b00;
    busy        = psel_q;
    bus.psel    = psel_q;
    bus.penable = penable_q;
    bus.paddr   = paddr_q;
    bus.pwrite  = pwrite_q;
    bus.pwdata  = pwdata_q;
    rsp_valid   = rsp_valid_q;
    rsp_err     = rsp_err_q;
    rsp_rdata   = rsp_rdata_q;
    dbg_state   = state_q;
  end

  // Datapath next values: latch the grant, count waits, build the response.
  // last_q equals the granted index for the whole transfer, so it steers rsp_valid.
  always_comb begin
    last_d      = last_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    // psel/penable come from flops so the bus sees glitch-free decodes.
    psel_d      = (state_d != IDLE);
    penable_d   = (state_d == ACCESS);
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          last_d   = gnt_idx;
          paddr_d  = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
          pwdata_d = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          pwrite_d = gnt_idx ? req_write[1] : req_write[0];
          cnt_d    = '0;
        end
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_valid_d = {last_q, ~last_q};
          rsp_err_d   = bus.pslverr;
          rsp_rdata_d = (!bus.pslverr && !pwrite_q) ? bus.prdata : '0;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            rsp_valid_d = {last_q, ~last_q};
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset drops any transfer in flight without a response.
  always_ff @(posedge pclk) begin
    if (preset) begin
      last_q      <= 1'b1;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      last_q      <= last_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-port APB master controller that shares the single APB slave bus (the `apb_ram` word memory) between two independent requesters. It round-robin arbitrates between them and sequences each granted request through the APB SETUP and ACCESS phases. It waits for `pready`, bounds the wait with a timeout, and returns read data and error status to the winning requester. It sits between requester logic (e.g. a DMA engine and a CPU-side port) and the APB slave interface signals.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, maximum ACCESS cycles waited for `pready` (legal range 2..255)

Ports:
- pclk  in  1  bus clock; all logic on rising edge
- preset  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i has a pending transfer
- req_write  in  2  bit i: 1 = write, 0 = read
- req_addr  in  2*ADDR_W  slice i = address of requester i
- req_wdata  in  2*DATA_W  slice i = write data of requester i
- req_ready  out  2  one-hot accept pulse; request i is consumed in the cycle `req_valid[i] & req_ready[i]`
- rsp_valid  out  2  one-hot, one-cycle response pulse to requester i
- rsp_rdata  out  DATA_W  read data (0 for writes, errors and timeouts); held until next response
- rsp_err  out  1  `pslverr` or timeout; qualified by `rsp_valid`
- busy  out  1  high in SETUP and ACCESS
- paddr  out  ADDR_W  APB address
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- psel  out  1  APB select
- penable  out  1  APB enable
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any `req_valid`, grant one requester, assert its `req_ready` (combinational, IDLE only), latch its write/addr/wdata into `paddr`/`pwrite`/`pwdata`, and go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration: round-robin on a 1-bit `last` pointer.
  - Both valid: grant `!last`.
  - One valid: grant that one.
  - `last` updates to the granted index on every grant.
  - After reset `last` = 1, so requester 0 wins the first tie.
- SETUP: `psel`=1, `penable`=0 for exactly one cycle, then ACCESS.
- ACCESS: `psel`=1, `penable`=1. Each cycle, sample `pready`.
  - `pready`=1:
    - capture `rsp_err` <= `pslverr`;
    - `rsp_rdata` <= `prdata` for an error-free read, else 0;
    - pulse `rsp_valid[grant]` next cycle;
    - go to IDLE.
  - `pready`=0:
    - increment the wait counter;
    - if the counter reaches TIMEOUT, go to IDLE with `rsp_err`=1, `rsp_rdata`=0 and `rsp_valid[grant]` pulsed.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the last ACCESS cycle. They keep their value in IDLE until the next grant.
- `psel` and `penable` are registered state decodes with no glitches. Both are 0 in IDLE.
- The wait counter clears on entry to SETUP. Width is 8 bits.
- Requests are not queued. A requester holds `req_valid` and its fields until it sees `req_ready`.

## Timing
- Reset (preset=1 at a clock edge):
  - state IDLE;
  - `psel`, `penable`, `pwrite`, `busy`, `rsp_valid`, `rsp_err` = 0;
  - `paddr`, `pwdata`, `rsp_rdata` = 0;
  - `last` = 1; counter = 0.
  - Reset in SETUP or ACCESS aborts the transfer silently: no `rsp_valid` is emitted.
- Latency against `apb_ram` (its `pready` is registered one cycle after it sees `penable`):
  - cycle 0: IDLE, accept;
  - cycle 1: SETUP;
  - cycle 2: ACCESS, `pready`=0;
  - cycle 3: ACCESS, `pready`=1;
  - cycle 4: `rsp_valid` pulses.
  - Total: 4 cycles from accept to response.
- `rsp_valid` coincides with IDLE, so a new grant can occur in the same cycle as the previous response.
- Minimum spacing between consecutive `psel` rises is 4 cycles. This gives `apb_ram` time to pass through its transfer state and return to its setup state.
- A request arriving while busy waits. It is arbitrated in the first IDLE cycle.
- Timeout case: the response is emitted on the cycle after the TIMEOUT-th ACCESS cycle with `pready` low. `psel` drops in that same cycle.

## Structure
- Package `apb_ctrl_pkg`: state enum `apb_mst_state_t` {IDLE, SETUP, ACCESS}, default ADDR_W/DATA_W constants, and `TIMEOUT_W`=8.
- Sub-module `apb_rr_arb2`: combinational two-input round-robin grant from (`req_valid`, `last`), producing a one-hot grant.
- The top holds the FSM, latched request, wait counter and response registers.

## Test plan
- Reset then a single write: requester 0 writes addr 5 = 0xDEADBEEF. Then requester 0 reads addr 5 -> `rsp_valid[0]` 4 cycles after accept, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Simultaneous requests: both `req_valid` high; requester 0 writes addr 1 = 0x11, requester 1 writes addr 2 = 0x22. Expected grant order 0, 1, 0, 1 over four back-to-back pairs. Readback of addr 1 gives 0x11 and of addr 2 gives 0x22.
- Out-of-range read: requester 1 reads addr 40 -> `rsp_err`=1, `rsp_rdata`=0, `rsp_valid[1]` only.
- Timeout: slave stubbed with `pready` tied 0 and TIMEOUT=4 -> exactly 4 ACCESS cycles, then `psel`=0, `rsp_err`=1, `rsp_valid` pulsed once.
- Reset mid-ACCESS: preset asserted in cycle 2 of a read -> all outputs 0 next cycle, no `rsp_valid`. The next request is granted to requester 0 on a tie.
- APB protocol checker: `penable` only follows a one-cycle `psel`-only phase, and `paddr`/`pwrite`/`pwdata` are stable while `psel` is high, for all scenarios above.
